flip_engine: RTL and testbench
==============================

// Module: flip_engine
// PURPOSE
//  Resolves one Reversi move against the board storage. On start it scans the 8 directions from
//  (moveX,moveY) through the board's combinational read port and flips bracketed opponent pieces
//  through the board's write port. It then places the mover's piece and reports the move's legality.
//  Sits directly upstream of the board: the game controller drives it, and it owns the board write port.
// PARAMETERS
//  width    8  board columns
//  height   8  board rows
//  busWidth 8  cell value width (must match the board)
// PORTS
//  clk        in  1                     system clock, all state on posedge
//  reset      in  1                     synchronous, active-high
//  start      in  1                     request move resolution; sampled only in IDLE
//  moveX      in  $clog2(width)         target column
//  moveY      in  $clog2(height)        target row
//  player     in  busWidth              mover's cell value (CELL_P1 or CELL_P2)
//  readX      out $clog2(width)         board read column
//  readY      out $clog2(height)        board read row
//  readValue  in  busWidth              board cell at (readX,readY), same cycle
//  writeEn    out 1                     board write strobe
//  writeX     out $clog2(width)         board write column
//  writeY     out $clog2(height)        board write row
//  writeValue out busWidth              value to write (always player)
//  busy       out 1                     high from the cycle after start acceptance until DONE
//  done       out 1                     1-cycle pulse at completion
//  legal      out 1                     valid with done; held until the next start is accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, legal=0, writeEn=0; read/write addresses 0; writeValue=0.
//  Opponent = the CELL_P1/CELL_P2 value that is not player. Cell encoding: 0 empty, 1 P1, 2 P2.
//  FSM: IDLE -> CHECK -> {SCAN <-> FLIP}* -> PLACE -> DONE -> IDLE.
//  IDLE: start=1 latches moveX/moveY/player, clears flip accumulator, sets direction d=0 -> CHECK.
//  CHECK (1 cycle): read target. If it is non-empty or coords >= width/height: legal=0 -> DONE.
//   Otherwise -> SCAN.
//  SCAN: the cursor starts at target+step(d); each cycle examines one position.
//   - Out of bounds or empty cell: discard the run; next d.
//   - Opponent cell: run++; advance the cursor.
//   - Own cell with run>0: -> FLIP. Own cell with run=0: next d.
//  FLIP: walk back toward the target one cell per cycle, writeEn=1, writeValue=player, run cycles.
//   Then set anyFlip and advance to the next d.
//  After d=7: if anyFlip -> PLACE, else legal=0 -> DONE.
//  PLACE (1 cycle): write player at the target; legal=1 -> DONE.
//  DONE (1 cycle): done=1, busy=0 next cycle; a start in this cycle is ignored.
//  Direction order d0..7 = N,NE,E,SE,S,SW,W,NW (N = y-1). Bounds are checked before every read.
//  writeEn is never asserted outside FLIP/PLACE. No writes occur for an illegal move.
//  The cursor uses one extra signed bit so that -1 and width/height are detectable.
//  Mid-operation reset returns to IDLE at once. Completed flips are not rolled back.
//  start while busy: ignored, not queued.
// CONFIGURATION
//  FLIP_COUNT_EN defined: adds output port flipCount [$clog2(width*height):0].
//   It holds the total pieces flipped (placed piece excluded), is valid with done and held like legal.
//  FLIP_COUNT_EN undefined: the port and its counter are absent; all else identical.
// STRUCTURE
//  Package board_pkg: CELL_EMPTY/CELL_P1/CELL_P2, the state enum, DIR_DX/DIR_DY step tables (8 entries).
//  One sub-module, board_cursor: bounds-checked x/y stepper.
//   It loads a start point, steps +/-step(d), and flags out-of-bounds.
// TESTING (bench pairs the engine with a real board instance, clear via reset)
//  1. Opening (3,3)=2,(4,4)=2,(4,3)=1,(3,4)=1; P1 at (2,3).
//     -> exactly two writes, (3,3)<=1 then (2,3)<=1; legal=1; flipCount=1.
//  2. Same board, P1 at (0,0) -> done with legal=0, writeEn never high, board unchanged.
//  3. Target (3,3) occupied -> done 2 cycles after start with legal=0, no writes.
//  4. Row 0: (1..6,0)=2, (7,0)=0; P1 at (0,0). Repeat with (7,0)=1.
//     -> first: legal=0; second: six flips then place, flipCount=6.
//  5. Target (3,3) with P2 at (3,2),(4,2),(4,3) and P1 at (3,1),(5,1),(5,3).
//     -> N, NE and E each flip 1 in that order; flipCount=3.
//  6. Reset asserted during the FLIP of test 4.
//     -> next cycle busy=0, writeEn=0, done never pulses; a new start is accepted normally.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board definitions: cell encoding, engine FSM states and the 8-direction step tables.
package board_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_P1    = 1;
  localparam int CELL_P2    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_FLIP,
    S_PLACE,
    S_DONE
  } state_e;

  // Direction order N, NE, E, SE, S, SW, W, NW with N meaning y-1.
  localparam logic signed [1:0] DIR_DX [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1};
  localparam logic signed [1:0] DIR_DY [8] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1};

endpackage

// File: rtl/flip_engine_if.sv
// Board access bus between flip_engine (master) and the board storage (slave).
interface flip_engine_if #(
  parameter int width    = 8,
  parameter int height   = 8,
  parameter int busWidth = 8
);
  logic [$clog2(width)-1:0]  readX;
  logic [$clog2(height)-1:0] readY;
  logic [busWidth-1:0]       readValue;
  logic                      writeEn;
  logic [$clog2(width)-1:0]  writeX;
  logic [$clog2(height)-1:0] writeY;
  logic [busWidth-1:0]       writeValue;

  modport master (
    output readX, readY, writeEn, writeX, writeY, writeValue,
    input  readValue
  );

  modport slave (
    input  readX, readY, writeEn, writeX, writeY, writeValue,
    output readValue
  );
endinterface

// File: rtl/board_cursor.sv
// Bounds-checked board cursor: loads base+step(dir), steps forward/back along dir, flags off-board.
module board_cursor
  import board_pkg::*;
#(
  parameter int width  = 8,
  parameter int height = 8
) (
  input  logic                      clk,
  input  logic                      load_i,
  input  logic                      adv_i,
  input  logic                      ret_i,
  input  logic [2:0]                dir_i,
  input  logic [$clog2(width)-1:0]  baseX_i,
  input  logic [$clog2(height)-1:0] baseY_i,
  output logic [$clog2(width)-1:0]  x_o,
  output logic [$clog2(height)-1:0] y_o,
  output logic                      oob_o
);
  localparam int XW = $clog2(width);
  localparam int YW = $clog2(height);
  localparam logic [XW:0] WID_L = (XW+1)'(width);
  localparam logic [YW:0] HGT_L = (YW+1)'(height);

  logic signed [XW:0] x_q, x_d;
  logic signed [YW:0] y_q, y_d;

  function automatic logic signed [XW:0] extX(input logic signed [1:0] s);
    return {{(XW-1){s[1]}}, s};
  endfunction

  function automatic logic signed [YW:0] extY(input logic signed [1:0] s);
    return {{(YW-1){s[1]}}, s};
  endfunction

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = $signed({1'b0, baseX_i}) + extX(DIR_DX[dir_i]);
      y_d = $signed({1'b0, baseY_i}) + extY(DIR_DY[dir_i]);
    end else if (adv_i) begin
      x_d = x_q + extX(DIR_DX[dir_i]);
      y_d = y_q + extY(DIR_DY[dir_i]);
    end else if (ret_i) begin
      x_d = x_q - extX(DIR_DX[dir_i]);
      y_d = y_q - extY(DIR_DY[dir_i]);
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  // The cursor only ever reaches -1..width, so a set top bit means -1 or >= 2^XW.
  assign oob_o = x_q[XW] | ({1'b0, x_q[XW-1:0]} >= WID_L) |
                 y_q[YW] | ({1'b0, y_q[YW-1:0]} >= HGT_L);
  assign x_o = x_q[XW-1:0];
  assign y_o = y_q[YW-1:0];

endmodule

// File: rtl/flip_engine.sv
// Reversi move resolver: scans 8 directions, flips bracketed runs, places the piece, reports legality.
// Optional FLIP_COUNT_EN macro adds the flipCount output (pieces flipped, placed piece excluded).
module flip_engine
  import board_pkg::*;
#(
  parameter int width    = 8,
  parameter int height   = 8,
  parameter int busWidth = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(width)-1:0]      moveX,
  input  logic [$clog2(height)-1:0]     moveY,
  input  logic [busWidth-1:0]           player,
  output logic                          busy,
  output logic                          done,
  output logic                          legal,
  flip_engine_if.master                 brd
`ifdef FLIP_COUNT_EN
  ,
  output logic [$clog2(width*height):0] flipCount
`endif
);
  localparam int XW = $clog2(width);
  localparam int YW = $clog2(height);
  localparam int RW = $clog2((width > height) ? width : height) + 1;
  localparam logic [XW:0] WID_L = (XW+1)'(width);
  localparam logic [YW:0] HGT_L = (YW+1)'(height);
  localparam logic [busWidth-1:0] EMPTY_V = busWidth'(CELL_EMPTY);
  localparam logic [busWidth-1:0] P1_V    = busWidth'(CELL_P1);
  localparam logic [busWidth-1:0] P2_V    = busWidth'(CELL_P2);

  state_e              state_q, state_d;
  logic [2:0]          d_q, d_d;
  logic [RW-1:0]       run_q, run_d;
  logic                anyFlip_q, anyFlip_d;
  logic                legal_q, legal_d;
  logic [XW-1:0]       mx_q;
  logic [YW-1:0]       my_q;
  logic [busWidth-1:0] player_q, oppV;
  logic                curLoad, curAdv, curRet, curOob, dirEnd;
  logic [2:0]          curDir;
  logic [XW-1:0]       curX;
  logic [YW-1:0]       curY;
`ifdef FLIP_COUNT_EN
  localparam int CW = $clog2(width*height) + 1;
  logic [CW-1:0]       cnt_q, cnt_d;
`endif

  board_cursor #(.width(width), .height(height)) u_cursor (
    .clk     (clk),
    .load_i  (curLoad),
    .adv_i   (curAdv),
    .ret_i   (curRet),
    .dir_i   (curDir),
    .baseX_i (mx_q),
    .baseY_i (my_q),
    .x_o     (curX),
    .y_o     (curY),
    .oob_o   (curOob)
  );

  assign oppV = (player_q == P1_V) ? P2_V : P1_V;

  always_comb begin
    state_d        = state_q;
    d_d            = d_q;
    run_d          = run_q;
    anyFlip_d      = anyFlip_q;
    legal_d        = legal_q;
    curLoad        = 1'b0;
    curAdv         = 1'b0;
    curRet         = 1'b0;
    curDir         = d_q;
    dirEnd         = 1'b0;
    brd.readX      = '0;
    brd.readY      = '0;
    brd.writeEn    = 1'b0;
    brd.writeX     = '0;
    brd.writeY     = '0;
    brd.writeValue = '0;
`ifdef FLIP_COUNT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          d_d       = 3'd0;
          run_d     = '0;
          anyFlip_d = 1'b0;
          legal_d   = 1'b0;
`ifdef FLIP_COUNT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_CHECK: begin
        brd.readX = mx_q;
        brd.readY = my_q;
        if (({1'b0, mx_q} >= WID_L) || ({1'b0, my_q} >= HGT_L) || (brd.readValue != EMPTY_V)) begin
          legal_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_SCAN;
          curLoad = 1'b1;
          curDir  = 3'd0;
          run_d   = '0;
        end
      end
      S_SCAN: begin
        if (curOob) begin
          dirEnd = 1'b1;
        end else begin
          brd.readX = curX;
          brd.readY = curY;
          if (brd.readValue == oppV) begin
            run_d  = run_q + RW'(1);
            curAdv = 1'b1;
          end else if ((brd.readValue == player_q) && (run_q != '0)) begin
            // Step back onto the last opponent cell before flipping toward the target.
            state_d = S_FLIP;
            curRet  = 1'b1;
          end else begin
            dirEnd = 1'b1;
          end
        end
      end
      S_FLIP: begin
        brd.writeEn    = 1'b1;
        brd.writeX     = curX;
        brd.writeY     = curY;
        brd.writeValue = player_q;
        curRet         = 1'b1;
        run_d          = run_q - RW'(1);
`ifdef FLIP_COUNT_EN
        cnt_d          = cnt_q + CW'(1);
`endif
        if (run_q == RW'(1)) begin
          anyFlip_d = 1'b1;
          dirEnd    = 1'b1;
        end
      end
      S_PLACE: begin
        brd.writeEn    = 1'b1;
        brd.writeX     = mx_q;
        brd.writeY     = my_q;
        brd.writeValue = player_q;
        legal_d        = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (dirEnd) begin
      run_d  = '0;
      curRet = 1'b0;
      if (d_q == 3'd7) begin
        state_d = anyFlip_d ? S_PLACE : S_DONE;
        if (!anyFlip_d) legal_d = 1'b0;
      end else begin
        d_d     = d_q + 3'd1;
        curLoad = 1'b1;
        curDir  = d_q + 3'd1;
        state_d = S_SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      d_q       <= '0;
      run_q     <= '0;
      anyFlip_q <= 1'b0;
      legal_q   <= 1'b0;
`ifdef FLIP_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      run_q     <= run_d;
      anyFlip_q <= anyFlip_d;
      legal_q   <= legal_d;
`ifdef FLIP_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      mx_q     <= moveX;
      my_q     <= moveY;
      player_q <= player;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign legal = legal_q;
`ifdef FLIP_COUNT_EN
  assign flipCount = cnt_q;
`endif

endmodule

// File: tb/tb_flip_engine.sv
// Directed bench for flip_engine paired with a bench-side 8x8 board; a move-level Reversi model
// predicts the ordered write list, legality and flip count for each move.
module tb_flip_engine;
  import board_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [2:0] moveX, moveY;
  logic [7:0] player;
  logic       busy, done, legal;
`ifdef FLIP_COUNT_EN
  logic [6:0] flipCount;
`endif

  flip_engine_if #(.width(8), .height(8), .busWidth(8)) bus ();

  flip_engine #(.width(8), .height(8), .busWidth(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .moveX  (moveX),
    .moveY  (moveY),
    .player (player),
    .busy   (busy),
    .done   (done),
    .legal  (legal),
    .brd    (bus.master)
`ifdef FLIP_COUNT_EN
    ,
    .flipCount (flipCount)
`endif
  );

  // Board storage: combinational read, write on posedge; bench preload and clear ports.
  logic [7:0] board [8][8];
  logic       tbClr, tbWe;
  logic [2:0] tbX, tbY;
  logic [7:0] tbV;

  assign bus.readValue = board[bus.readY][bus.readX];

  always @(posedge clk) begin
    if (tbClr) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          board[y][x] <= 8'd0;
    end else if (tbWe) begin
      board[tbY][tbX] <= tbV;
    end else if (bus.writeEn) begin
      board[bus.writeY][bus.writeX] <= bus.writeValue;
    end
  end

  int checks = 0;
  int errors = 0;

  int expQ[$];
  int actW[$];
  int mLegal, mCnt;
  int lastLegal, lastLat, lastCnt;
  logic [7:0] snap [8][8];

  int dxT[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyT[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit inb(input int x, input int y);
    return (x >= 0 && x < 8 && y >= 0 && y < 8);
  endfunction

  // Reversi rules on the current board; writes are coded x*16+y in the order they must appear.
  task automatic model_move(input int mx, input int my, input int p);
    int opp, x, y, n;
    expQ.delete();
    mLegal = 0;
    mCnt   = 0;
    if (int'(board[my][mx]) != 0) return;
    opp = (p == 1) ? 2 : 1;
    for (int d = 0; d < 8; d++) begin
      x = mx + dxT[d];
      y = my + dyT[d];
      n = 0;
      while (inb(x, y) && int'(board[y][x]) == opp) begin
        n++;
        x += dxT[d];
        y += dyT[d];
      end
      if (n > 0 && inb(x, y) && int'(board[y][x]) == p) begin
        for (int k = n; k >= 1; k--)
          expQ.push_back((mx + k*dxT[d])*16 + (my + k*dyT[d]));
        mCnt += n;
      end
    end
    if (mCnt > 0) begin
      expQ.push_back(mx*16 + my);
      mLegal = 1;
    end
  endtask

  task automatic set_cell(input int x, input int y, input int v);
    @(negedge clk);
    tbWe = 1'b1; tbX = 3'(x); tbY = 3'(y); tbV = 8'(v);
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  task automatic clear_board();
    @(negedge clk);
    tbClr = 1'b1;
    @(negedge clk);
    tbClr = 1'b0;
  endtask

  task automatic opening();
    clear_board();
    set_cell(3, 3, 2); set_cell(4, 4, 2); set_cell(4, 3, 1); set_cell(3, 4, 1);
  endtask

  task automatic run_move(input int mx, input int my, input int p, input string tag);
    bit seen;
    int code;
    model_move(mx, my, p);
    actW.delete();
    lastLegal = -1; lastLat = -1; lastCnt = -1;
    @(negedge clk);
    start = 1'b1; moveX = 3'(mx); moveY = 3'(my); player = 8'(p);
    @(posedge clk);
    seen = 1'b0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.writeEn) begin
        code = int'(bus.writeX)*16 + int'(bus.writeY);
        actW.push_back(code);
        if (expQ.size() == 0) chk({tag, " unexpected write"}, code, -1);
        else chk({tag, " write addr"}, code, expQ.pop_front());
        chk({tag, " write value"}, int'(bus.writeValue), p);
      end
      if (done) begin
        seen = 1'b1;
        lastLat = c;
        lastLegal = int'(legal);
        chk({tag, " legal vs model"}, int'(legal), mLegal);
        chk({tag, " busy during done"}, int'(busy), 1);
        chk({tag, " missing writes"}, expQ.size(), 0);
`ifdef FLIP_COUNT_EN
        lastCnt = int'(flipCount);
        chk({tag, " flipCount vs model"}, int'(flipCount), mCnt);
`endif
      end
    end
    if (!seen) chk({tag, " done timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, " done one cycle"}, int'(done), 0);
    chk({tag, " busy after done"}, int'(busy), 0);
    chk({tag, " legal held"}, int'(legal), mLegal);
  endtask

  initial begin
    int diffs, dpulse;
    bit hit;
    reset = 1'b1; start = 1'b0; moveX = '0; moveY = '0; player = '0;
    tbClr = 1'b1; tbWe = 1'b0; tbX = '0; tbY = '0; tbV = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset legal", int'(legal), 0);
    chk("reset writeEn", int'(bus.writeEn), 0);
    chk("reset readX", int'(bus.readX), 0);
    chk("reset readY", int'(bus.readY), 0);
    chk("reset writeX", int'(bus.writeX), 0);
    chk("reset writeY", int'(bus.writeY), 0);
    chk("reset writeValue", int'(bus.writeValue), 0);
    reset = 1'b0; tbClr = 1'b0;

    // Opening move P1 at (2,3): flips (3,3) then places (2,3).
    opening();
    run_move(2, 3, 1, "t1");
    chk("t1 legal", lastLegal, 1);
    chk("t1 nwrites", actW.size(), 2);
    chk("t1 write0", actW.size() > 0 ? actW[0] : -1, 3*16 + 3);
    chk("t1 write1", actW.size() > 1 ? actW[1] : -1, 2*16 + 3);
`ifdef FLIP_COUNT_EN
    chk("t1 flipCount", lastCnt, 1);
`endif

    // Corner move with nothing bracketed: illegal, board untouched.
    opening();
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) snap[y][x] = board[y][x];
    run_move(0, 0, 1, "t2");
    chk("t2 legal", lastLegal, 0);
    chk("t2 nwrites", actW.size(), 0);
    diffs = 0;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) if (snap[y][x] != board[y][x]) diffs++;
    chk("t2 board diffs", diffs, 0);

    // Occupied target: done two cycles after start.
    run_move(3, 3, 1, "t3");
    chk("t3 legal", lastLegal, 0);
    chk("t3 latency", lastLat, 2);
    chk("t3 nwrites", actW.size(), 0);

    // Row 0 run of six P2 pieces, open-ended then closed by P1.
    clear_board();
    for (int x = 1; x <= 6; x++) set_cell(x, 0, 2);
    run_move(0, 0, 1, "t4a");
    chk("t4a legal", lastLegal, 0);
    chk("t4a nwrites", actW.size(), 0);
    set_cell(7, 0, 1);
    run_move(0, 0, 1, "t4b");
    chk("t4b legal", lastLegal, 1);
    chk("t4b nwrites", actW.size(), 7);
    chk("t4b first flip", actW.size() > 0 ? actW[0] : -1, 6*16 + 0);
    chk("t4b last flip", actW.size() > 5 ? actW[5] : -1, 1*16 + 0);
    chk("t4b place", actW.size() > 6 ? actW[6] : -1, 0*16 + 0);
`ifdef FLIP_COUNT_EN
    chk("t4b flipCount", lastCnt, 6);
`endif

    // Three directions N, NE, E each bracket one piece.
    clear_board();
    set_cell(3, 2, 2); set_cell(4, 2, 2); set_cell(4, 3, 2);
    set_cell(3, 1, 1); set_cell(5, 1, 1); set_cell(5, 3, 1);
    run_move(3, 3, 1, "t5");
    chk("t5 legal", lastLegal, 1);
    chk("t5 nwrites", actW.size(), 4);
    chk("t5 N", actW.size() > 0 ? actW[0] : -1, 3*16 + 2);
    chk("t5 NE", actW.size() > 1 ? actW[1] : -1, 4*16 + 2);
    chk("t5 E", actW.size() > 2 ? actW[2] : -1, 4*16 + 3);
    chk("t5 place", actW.size() > 3 ? actW[3] : -1, 3*16 + 3);
`ifdef FLIP_COUNT_EN
    chk("t5 flipCount", lastCnt, 3);
`endif

    // Reset in the middle of a flip run.
    clear_board();
    for (int x = 1; x <= 6; x++) set_cell(x, 0, 2);
    set_cell(7, 0, 1);
    @(negedge clk);
    start = 1'b1; moveX = 3'd0; moveY = 3'd0; player = 8'd1;
    @(posedge clk);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.writeEn) hit = 1'b1;
    end
    chk("t6 reached flip", int'(hit), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6 busy after reset", int'(busy), 0);
    chk("t6 writeEn after reset", int'(bus.writeEn), 0);
    chk("t6 legal after reset", int'(legal), 0);
    reset = 1'b0;
    dpulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || bus.writeEn) dpulse++;
    end
    chk("t6 no done or write after reset", dpulse, 0);
    opening();
    run_move(2, 3, 1, "t6 restart");
    chk("t6 restart legal", lastLegal, 1);
    chk("t6 restart nwrites", actW.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
